immediate_reader: RTL and testbench
===================================

# immediate_reader

Fetches the 8- or 16-bit immediate/displacement that follows an opcode or ModR/M byte from the instruction-stream byte FIFO and presents it as a 16-bit value. Sits between the prefetch FIFO read port and its consumers (ModR/M decode, opcode immediates). 8-bit values are sign-extended to 16 bits. Handshake is start-level / complete-pulse, and the block tolerates an empty FIFO at any point.

## Interface
Parameters: none.
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; level, held high by consumer until complete
- is_8bit  input  1  1 = one-byte immediate (sign-extended), 0 = two-byte little-endian; sampled with start in IDLE
- flush  input  1  synchronous abort (branch/redirect); discards partial fetch
- busy  output  1  start | (state != IDLE)
- complete  output  1  one-cycle pulse; immediate valid this cycle
- immediate  output  16  fetched value; held after complete until next complete or reset
- fifo_rd_en  output  1  pop request to byte FIFO
- fifo_rd_data  input  8  FIFO data, valid the cycle after fifo_rd_en
- fifo_empty  input  1  FIFO has no byte available

## Operation
- FSM states: IDLE, LO_PEND (low byte on fifo_rd_data), NEED_HI (waiting for FIFO for high byte), HI_PEND (high byte on fifo_rd_data).
- fifo_rd_en = ~fifo_empty & ~flush & ((IDLE & start) | NEED_HI | (LO_PEND & ~width8)); never asserted in a completing cycle.
- IDLE: if start & fifo_rd_en, capture is_8bit into width8 and go LO_PEND; else stay (empty FIFO stalls, no timeout).
- LO_PEND: capture fifo_rd_data into lo register.
  - width8: complete=1, immediate = {{8{fifo_rd_data[7]}}, fifo_rd_data}, register it, go IDLE.
  - 16-bit: go HI_PEND if fifo_rd_en, else go NEED_HI.
- NEED_HI: go HI_PEND when fifo_rd_en.
- HI_PEND: complete=1, immediate = {fifo_rd_data, lo}, register it, go IDLE.
- immediate output: combinational value during the complete cycle, registered copy otherwise.
- start is not re-examined after leaving IDLE; a consumer dropping start mid-fetch is a protocol violation, and the block still completes.
- In the complete cycle, start is still high but no new fetch starts. The consumer deasserts start on the next edge. A re-assertion after that begins a new fetch.
- flush: next state IDLE from any state, fifo_rd_en=0 and complete=0 that cycle; immediate register is unchanged and the lo byte is discarded.
- reset: state IDLE, width8=0, lo=0, immediate register=0. Outputs during and after reset: busy=start, complete=0, fifo_rd_en=0, immediate=0x0000.
- reset has priority over flush; flush has priority over start/complete.

## Timing
- Non-empty FIFO: 8-bit completes 1 cycle after the start cycle (2-cycle occupancy); 16-bit completes 2 cycles after.
- Each cycle of fifo_empty while a byte is needed adds exactly one cycle; no byte is popped while empty.
- Consecutive fetches: minimum one idle cycle between complete and the next start being honoured (consumer deassert edge).
- complete is never asserted on two consecutive cycles.
- fifo_rd_data is only sampled in LO_PEND/HI_PEND, the cycle after a pop.

## Test plan
- Reset, then 8-bit fetch with FIFO byte 0x85: fifo_rd_en in cycle 0, complete in cycle 1, immediate=0xFF85; 0x7F gives 0x007F; value held after start drops.
- 16-bit fetch, FIFO bytes 0x34, 0x12 back-to-back: pops in cycles 0 and 1, complete in cycle 2, immediate=0x1234, exactly two pops.
- 16-bit fetch with fifo_empty high for 3 cycles between bytes: state NEED_HI, no pops while empty, complete 3 cycles late, immediate correct, busy high throughout.
- start with FIFO empty for 5 cycles, then byte 0x01 (8-bit): no pop until non-empty, then complete one cycle later with 0x0001.
- flush in HI_PEND/NEED_HI of a 16-bit fetch: no complete, state IDLE; immediate keeps the previous 0x1234. Next 8-bit fetch of 0x80 yields 0xFF80.
- reset asserted mid 16-bit fetch: next cycle busy=start, complete=0, immediate=0x0000, no pop; a fresh fetch after reset completes normally.

Source files
------------

// File: rtl/immediate_reader.sv
// Fetches an 8-bit (sign-extended) or 16-bit little-endian immediate from the prefetch byte FIFO.
// Latency: complete 1 cycle after the start cycle (8-bit) or 2 cycles after (16-bit), +1 per empty-FIFO cycle.
// Backpressure: an empty FIFO stalls the fetch indefinitely; no byte is popped while empty; flush aborts.
module immediate_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_8bit,
  input  logic        flush,
  output logic        busy,
  output logic        complete,
  output logic [15:0] immediate,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_rd_data,
  input  logic        fifo_empty
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LO_PEND = 2'd1,
    NEED_HI = 2'd2,
    HI_PEND = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        width8;
  logic [7:0]  lo;
  logic [15:0] imm_reg;
  logic [15:0] imm_val;
  logic        pop_ok;

  // A pop is only legal when a byte exists and no abort/reset is in progress.
  assign pop_ok = ~fifo_empty & ~flush & ~reset;

  // Next-state, FIFO pop and completion decode.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    complete   = 1'b0;
    imm_val    = imm_reg;
    case (state)
      IDLE: begin
        if (start && pop_ok) begin
          fifo_rd_en = 1'b1;
          state_nxt  = LO_PEND;
        end
      end
      LO_PEND: begin
        if (width8) begin
          complete  = 1'b1;
          imm_val   = {{8{fifo_rd_data[7]}}, fifo_rd_data};
          state_nxt = IDLE;
        end else if (pop_ok) begin
          fifo_rd_en = 1'b1;
          state_nxt  = HI_PEND;
        end else begin
          state_nxt = NEED_HI;
        end
      end
      NEED_HI: begin
        if (pop_ok) begin
          fifo_rd_en = 1'b1;
          state_nxt  = HI_PEND;
        end
      end
      HI_PEND: begin
        complete  = 1'b1;
        imm_val   = {fifo_rd_data, lo};
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort wins over any completion; the held immediate is left untouched.
    if (flush || reset) begin
      state_nxt = IDLE;
      complete  = 1'b0;
    end
  end

  // Status and result: the fresh value is forwarded in the complete cycle, the held copy otherwise.
  always_comb begin
    busy = start | (~reset & (state != IDLE));
    if (reset) begin
      immediate = 16'h0000;
    end else if (complete) begin
      immediate = imm_val;
    end else begin
      immediate = imm_reg;
    end
  end

  // State, width, low byte and held immediate registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      width8  <= 1'b0;
      lo      <= 8'h00;
      imm_reg <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == IDLE && fifo_rd_en) begin
        width8 <= is_8bit;
      end
      if (state == LO_PEND && !flush) begin
        lo <= fifo_rd_data;
      end
      if (complete) begin
        imm_reg <= imm_val;
      end
    end
  end

endmodule

// File: tb/tb_immediate_reader.sv
// Bench for immediate_reader: directed steps from the test plan followed by randomized traffic.
// Expected outputs come from a byte-counting transaction model, compared every cycle.
// The bench plays both the byte FIFO and the consumer.
module tb_immediate_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_8bit;
  logic        flush;
  logic        busy;
  logic        complete;
  logic [15:0] immediate;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;

  int checks;
  int failures;

  // FIFO contents supplied by the bench
  logic [7:0] fifo_q[$];

  // Reference model: a fetch in progress, bytes still to pop, bytes received
  bit          m_active;
  bit          m_w8;
  bit          m_arrive;
  int          m_need;
  int          m_got;
  logic [7:0]  m_lo;
  logic [15:0] m_imm;

  logic last_comp;
  logic last_pop;
  int   pop_cnt;

  immediate_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_8bit      (is_8bit),
    .flush        (flush),
    .busy         (busy),
    .complete     (complete),
    .immediate    (immediate),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check all outputs against the model, advance model and FIFO.
  task automatic cyc(input logic st, input logic w8, input logic fl, input logic rs, input logic em);
    logic        e_busy;
    logic        e_pop;
    logic        e_comp;
    logic [15:0] e_val;
    logic [15:0] e_imm;
    logic        dut_pop;
    start      = st;
    is_8bit    = w8;
    flush      = fl;
    reset      = rs;
    fifo_empty = em;
    @(negedge clk);
    if (rs) begin
      e_busy = st;
      e_pop  = 1'b0;
      e_comp = 1'b0;
      e_val  = 16'h0000;
      e_imm  = 16'h0000;
    end else begin
      e_busy = st | m_active;
      e_pop  = !fl && !em && (m_active ? (m_need > 0) : st);
      e_comp = !fl && m_active && m_arrive && (m_got + 1 == (m_w8 ? 1 : 2));
      e_val  = m_w8 ? 16'($signed(fifo_rd_data)) : {fifo_rd_data, m_lo};
      e_imm  = e_comp ? e_val : m_imm;
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(e_pop));
    chk("complete", 32'(complete), 32'(e_comp));
    chk("immediate", 32'(immediate), 32'(e_imm));
    dut_pop   = fifo_rd_en;
    last_comp = complete;
    last_pop  = fifo_rd_en;
    if (fifo_rd_en) pop_cnt++;
    // advance model
    if (rs) begin
      m_active = 0; m_arrive = 0; m_need = 0; m_got = 0; m_w8 = 0;
      m_lo = 8'h00; m_imm = 16'h0000;
    end else if (fl) begin
      m_active = 0; m_arrive = 0;
    end else if (e_comp) begin
      m_imm = e_val; m_active = 0; m_arrive = 0;
    end else begin
      if (m_arrive) begin
        m_lo = fifo_rd_data;
        m_got++;
      end
      if (e_pop) begin
        if (!m_active) begin
          m_active = 1; m_w8 = w8; m_need = w8 ? 0 : 1; m_got = 0;
        end else begin
          m_need--;
        end
        m_arrive = 1;
      end else begin
        m_arrive = 0;
      end
    end
    @(posedge clk);
    #1;
    if (dut_pop && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
    else fifo_rd_data = 8'($urandom);
  endtask

  // Consumer-side fetch: hold start until complete, FIFO empty for e0 cycles before the
  // first pop and e1 cycles before the second, then drop start for one cycle.
  task automatic fetch(input logic w8, input int e0, input int e1);
    int   pops;
    int   cycles;
    int   r0;
    int   r1;
    logic em;
    logic done;
    pops = 0; cycles = 0; r0 = e0; r1 = e1; done = 1'b0;
    while (!done && cycles < 40) begin
      em = (pops == 0 && r0 > 0) || (pops == 1 && r1 > 0);
      if (em) begin
        if (pops == 0) r0--;
        else r1--;
      end
      cyc(1'b1, w8, 1'b0, 1'b0, em);
      if (last_pop) pops++;
      cycles++;
      done = last_comp;
    end
    chk("fetch_done", 32'(done), 32'd1);
    chk("fetch_latency", 32'(cycles), 32'((w8 ? 2 : 3) + e0 + e1));
    chk("fetch_pops", 32'(pops), 32'(w8 ? 1 : 2));
    cyc(1'b0, w8, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic req;
    logic req_w8;
    logic gap;
    logic fl;
    logic rs;
    checks = 0; failures = 0; pop_cnt = 0;
    m_active = 0; m_arrive = 0; m_need = 0; m_got = 0; m_w8 = 0;
    m_lo = 8'h00; m_imm = 16'h0000;
    last_comp = 0; last_pop = 0;
    start = 0; is_8bit = 0; flush = 0; reset = 1; fifo_empty = 1; fifo_rd_data = 8'h00;

    // reset state, with start both low and high
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_imm", 32'(immediate), 32'h0000);

    // 8-bit negative and positive
    fifo_q.push_back(8'h85);
    fetch(1'b1, 0, 0);
    chk("imm_ff85", 32'(immediate), 32'hFF85);
    fifo_q.push_back(8'h7F);
    fetch(1'b1, 0, 0);
    chk("imm_007f", 32'(immediate), 32'h007F);

    // 16-bit with three empty cycles between bytes
    fifo_q.push_back(8'hCD); fifo_q.push_back(8'hAB);
    fetch(1'b0, 0, 3);
    chk("imm_abcd", 32'(immediate), 32'hABCD);

    // 8-bit with FIFO empty for five cycles at start
    fifo_q.push_back(8'h01);
    fetch(1'b1, 5, 0);
    chk("imm_0001", 32'(immediate), 32'h0001);

    // 16-bit back-to-back
    pop_cnt = 0;
    fifo_q.push_back(8'h34); fifo_q.push_back(8'h12);
    fetch(1'b0, 0, 0);
    chk("imm_1234", 32'(immediate), 32'h1234);
    chk("pops_1234", 32'(pop_cnt), 32'd2);

    // flush while waiting for the high byte
    fifo_q.delete();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_needhi_imm", 32'(immediate), 32'h1234);
    chk("flush_needhi_busy", 32'(busy), 32'd0);

    // flush with the high byte on the bus
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush_hipend_imm", 32'(immediate), 32'h1234);

    fifo_q.delete();
    fifo_q.push_back(8'h80);
    fetch(1'b1, 0, 0);
    chk("imm_ff80", 32'(immediate), 32'hFF80);

    // reset in the middle of a 16-bit fetch
    fifo_q.delete();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midreset_imm", 32'(immediate), 32'h0000);
    fifo_q.push_back(8'h5A); fifo_q.push_back(8'hA5);
    fetch(1'b0, 0, 0);
    chk("imm_a55a", 32'(immediate), 32'hA55A);

    // randomized traffic
    fifo_q.delete();
    req = 0; req_w8 = 0; gap = 0;
    for (int i = 0; i < 600; i++) begin
      if (!req && !gap && ($urandom % 3 == 0)) begin
        req    = 1;
        req_w8 = 1'($urandom);
      end
      gap = 0;
      fl  = ($urandom % 40 == 0);
      rs  = ($urandom % 150 == 0);
      cyc(req, req ? req_w8 : 1'($urandom), fl, rs, ($urandom % 4 == 0));
      if (last_comp || fl || rs) begin
        if (req) gap = 1;
        req = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
